interrupt_control_unit: RTL and testbench

Interrupt control unit (ICU) for the five-stage pipeline. It detects a rising edge on the external interrupt pin and raises `int_flag` to the control unit, which then releases its shared control lines to high-Z. The ICU then drives those lines through a fixed hardware sequence: push the captured PC (high word, then low word), push the flags, then load the PC from the interrupt vector. It sits beside the control unit in the decode stage, and its outputs share the same control nets into the ID/EX register.

---
 rtl/interrupt_control_unit.sv | 159 +++++++++++++++
 tb/tb_interrupt_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_control_unit.sv
// Interrupt control unit: edge-detects the external interrupt pin, then takes over the
// shared decode-stage control lines to push PC and flags and load the ISR vector.
module interrupt_control_unit #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0000,
  parameter logic [3:0]  PUSH_ALU    = 4'b0100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                int_req_i,
  input  logic                stall_i,
  input  logic [PC_WIDTH-1:0] pc_in_i,
  input  logic [3:0]          flags_in_i,
  output logic                int_flag_o,
  output logic                int_ack_o,
  output logic [3:0]          alu_function_o,
  output logic                branch_o,
  output logic                data_read_o,
  output logic                data_write_o,
  output logic                dmw_o,
  output logic                stack_operation_o,
  output logic                push_pop_o,
  output logic                write_sp_o,
  output logic [15:0]         push_data_o,
  output logic                vec_read_o,
  output logic [31:0]         vec_addr_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_HI  = 3'd1,
    PUSH_LO  = 3'd2,
    PUSH_FLG = 3'd3,
    LOAD_VEC = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic                req_dly_q, req_dly_d;
  logic [PC_WIDTH-1:0] saved_pc_q, saved_pc_d;
  logic [3:0]          saved_flags_q, saved_flags_d;
  logic                edge_s;

  assign edge_s = int_req_i & ~req_dly_q;

  // State and capture registers; everything freezes while the pipeline stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      req_dly_q     <= 1'b0;
      saved_pc_q    <= '0;
      saved_flags_q <= 4'b0000;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      req_dly_q     <= req_dly_d;
      saved_pc_q    <= saved_pc_d;
      saved_flags_q <= saved_flags_d;
    end
  end

  // Next-state logic; a new edge overrides the clear taken on sequence start.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    req_dly_d     = req_dly_q;
    saved_pc_d    = saved_pc_q;
    saved_flags_d = saved_flags_q;
    if (!stall_i) begin
      req_dly_d = int_req_i;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_d       = PUSH_HI;
            pending_d     = 1'b0;
            saved_pc_d    = pc_in_i;
            saved_flags_d = flags_in_i;
          end else begin
            state_d = IDLE;
          end
        end
        PUSH_HI:  state_d = PUSH_LO;
        PUSH_LO:  state_d = PUSH_FLG;
        PUSH_FLG: state_d = LOAD_VEC;
        LOAD_VEC: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
      if (edge_s) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  logic        own_s;
  logic [3:0]  alu_s;
  logic        branch_s, dread_s, dwrite_s, dmw_s, stack_s, pp_s, wsp_s;
  logic        ack_s, vrd_s;
  logic [15:0] pdata_s;

  // Output decode straight from the state register.
  always_comb begin
    own_s    = 1'b1;
    alu_s    = 4'b0000;
    branch_s = 1'b0;
    dread_s  = 1'b0;
    dwrite_s = 1'b0;
    dmw_s    = 1'b0;
    stack_s  = 1'b0;
    pp_s     = 1'b0;
    wsp_s    = 1'b0;
    ack_s    = 1'b0;
    vrd_s    = 1'b0;
    pdata_s  = 16'h0000;
    case (state_q)
      IDLE: own_s = 1'b0;
      PUSH_HI, PUSH_LO, PUSH_FLG: begin
        alu_s   = PUSH_ALU;
        dmw_s   = 1'b1;
        stack_s = 1'b1;
        pp_s    = 1'b1;
        wsp_s   = 1'b1;
        if (state_q == PUSH_HI) begin
          pdata_s = saved_pc_q[PC_WIDTH-1 -: 16];
        end else if (state_q == PUSH_LO) begin
          pdata_s = saved_pc_q[15:0];
        end else begin
          pdata_s = {12'h000, saved_flags_q};
        end
      end
      LOAD_VEC: begin
        branch_s = 1'b1;
        vrd_s    = 1'b1;
        ack_s    = 1'b1;
      end
      default: own_s = 1'b0;
    endcase
  end

  // Shared lines float whenever the control unit owns them.
  assign int_flag_o        = own_s;
  assign int_ack_o         = ack_s;
  assign vec_read_o        = vrd_s;
  assign vec_addr_o        = vrd_s ? VECTOR_ADDR : 32'h0000_0000;
  assign push_data_o       = pdata_s;
  assign alu_function_o    = own_s ? alu_s    : 4'bzzzz;
  assign branch_o          = own_s ? branch_s : 1'bz;
  assign data_read_o       = own_s ? dread_s  : 1'bz;
  assign data_write_o      = own_s ? dwrite_s : 1'bz;
  assign dmw_o             = own_s ? dmw_s    : 1'bz;
  assign stack_operation_o = own_s ? stack_s  : 1'bz;
  assign push_pop_o        = own_s ? pp_s     : 1'bz;
  assign write_sp_o        = own_s ? wsp_s    : 1'bz;

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Directed bench for interrupt_control_unit: push sequence, stall, retrigger,
// level hold, asynchronous reset and idle isolation.
module tb_interrupt_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_req = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_in = 32'h0000_0000;
  logic [3:0]  flags_in = 4'b0000;
  wire         int_flag, int_ack, branch, data_read, data_write, dmw;
  wire         stack_op, push_pop, write_sp, vec_read;
  wire  [3:0]  alu_function;
  wire  [15:0] push_data;
  wire  [31:0] vec_addr;

  int checks = 0;
  int failures = 0;

  interrupt_control_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .int_req_i        (int_req),
    .stall_i          (stall),
    .pc_in_i          (pc_in),
    .flags_in_i       (flags_in),
    .int_flag_o       (int_flag),
    .int_ack_o        (int_ack),
    .alu_function_o   (alu_function),
    .branch_o         (branch),
    .data_read_o      (data_read),
    .data_write_o     (data_write),
    .dmw_o            (dmw),
    .stack_operation_o(stack_op),
    .push_pop_o       (push_pop),
    .write_sp_o       (write_sp),
    .push_data_o      (push_data),
    .vec_read_o       (vec_read),
    .vec_addr_o       (vec_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of shared-line bits actively driven high (released lines must show none).
  function automatic int shared_high();
    logic [10:0] v;
    int n;
    v = {alu_function, branch, data_read, data_write, dmw, stack_op, push_pop, write_sp};
    n = 0;
    for (int i = 0; i < 11; i++) if (v[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic expect_idle(input string tag);
    check({tag, "_flag"}, {31'd0, int_flag}, 32'd0);
    check({tag, "_ack"}, {31'd0, int_ack}, 32'd0);
    check({tag, "_vrd"}, {31'd0, vec_read}, 32'd0);
    check({tag, "_pdata"}, {16'd0, push_data}, 32'd0);
    check({tag, "_vaddr"}, vec_addr, 32'd0);
    check({tag, "_shared_hi"}, shared_high(), 32'd0);
  endtask

  task automatic expect_push(input string tag, input logic [15:0] data);
    check({tag, "_flag"}, {31'd0, int_flag}, 32'd1);
    check({tag, "_pdata"}, {16'd0, push_data}, {16'd0, data});
    check({tag, "_ctl"}, {21'd0, alu_function, branch, data_read, data_write, dmw,
                          stack_op, push_pop, write_sp}, {21'd0, 4'b0100, 7'b000_1111});
    check({tag, "_vrd_ack"}, {30'd0, vec_read, int_ack}, 32'd0);
  endtask

  task automatic expect_load(input string tag);
    check({tag, "_flag"}, {31'd0, int_flag}, 32'd1);
    check({tag, "_ctl"}, {21'd0, alu_function, branch, data_read, data_write, dmw,
                          stack_op, push_pop, write_sp}, {21'd0, 4'b0000, 7'b100_0000});
    check({tag, "_vrd_ack"}, {30'd0, vec_read, int_ack}, 32'd3);
    check({tag, "_vaddr"}, vec_addr, 32'h0000_0000);
    check({tag, "_pdata"}, {16'd0, push_data}, 32'd0);
  endtask

  initial begin
    int nflag, nack, nbad;

    // Reset state
    #1;
    expect_idle("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    expect_idle("post_reset");

    // Single interrupt
    pc_in = 32'h0001_0020;
    flags_in = 4'b1010;
    int_req = 1'b1;
    tick();
    check("pending_no_own", {31'd0, int_flag}, 32'd0);
    int_req = 1'b0;
    tick(); expect_push("s_hi", 16'h0001);
    tick(); expect_push("s_lo", 16'h0020);
    tick(); expect_push("s_flg", 16'h000A);
    tick(); expect_load("s_load");
    tick(); expect_idle("s_idle");

    // Ownership length and ack pulse count
    nflag = 0; nack = 0;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_flag === 1'b1) nflag++;
      if (int_ack === 1'b1) nack++;
    end
    check("own_cycles", nflag, 32'd4);
    check("ack_pulses", nack, 32'd1);

    // Stall for two cycles in PUSH_LO with pc_in changing
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick(); expect_push("st_hi", 16'h0001);
    tick(); expect_push("st_lo0", 16'h0020);
    stall = 1'b1;
    pc_in = 32'hDEAD_BEEF;
    tick(); expect_push("st_lo1", 16'h0020);
    pc_in = 32'hCAFE_F00D;
    tick(); expect_push("st_lo2", 16'h0020);
    stall = 1'b0;
    tick(); expect_push("st_flg", 16'h000A);
    tick(); expect_load("st_load");
    tick(); expect_idle("st_idle");

    // Retrigger during PUSH_FLG
    pc_in = 32'h0001_0020;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick(); expect_push("rt_hi", 16'h0001);
    tick(); expect_push("rt_lo", 16'h0020);
    tick(); expect_push("rt_flg", 16'h000A);
    int_req = 1'b1;
    pc_in = 32'h1234_5678;
    flags_in = 4'b0101;
    tick(); expect_load("rt_load");
    int_req = 1'b0;
    tick(); expect_idle("rt_gap");
    tick(); expect_push("rt2_hi", 16'h1234);
    tick(); expect_push("rt2_lo", 16'h5678);
    tick(); expect_push("rt2_flg", 16'h0005);
    tick(); expect_load("rt2_load");
    tick(); expect_idle("rt2_idle");

    // Level held high for 20 cycles
    nflag = 0; nack = 0;
    int_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) int_req = 1'b0;
      tick();
      if (int_flag === 1'b1) nflag++;
      if (int_ack === 1'b1) nack++;
    end
    check("level_own_cycles", nflag, 32'd4);
    check("level_ack_pulses", nack, 32'd1);

    // Reset in PUSH_LO
    pc_in = 32'h0001_0020;
    flags_in = 4'b1010;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick(); expect_push("rs_hi", 16'h0001);
    tick(); expect_push("rs_lo", 16'h0020);
    #2;
    rst_n = 1'b0;
    #1;
    expect_idle("rs_async");
    #2;
    rst_n = 1'b1;
    nflag = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_flag === 1'b1) nflag++;
    end
    check("rs_no_rerun", nflag, 32'd0);

    // Idle isolation for 50 cycles
    nbad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (int_flag !== 1'b0 || shared_high() != 0) nbad++;
    end
    check("idle_isolation", nbad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
